spart_tx: RTL
=============

# spart_tx

Serial transmitter half of the SPART. Accepts a byte from the bus interface into a one-entry holding buffer, then serializes it on `txd` as an 8N1 frame: one start bit (0), eight data bits LSB first, one stop bit (1). Bit timing comes from the shared baud generator's `tx_enable` tick at 16x the baud rate, the same tick rate the SPART receiver oversamples at. The holding buffer plus shift register allow back-to-back frames with no idle gap.

## Interface
Parameters: none (frame format fixed at 8N1, oversample fixed at 16).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `tx_enable`  in  1  baud tick, one-`clk` pulse at 16x baud rate.
- `write`  in  1  one-`clk` strobe: load `tx_data` into the holding buffer.
- `tx_data`  in  8  byte to transmit, sampled when `write`=1.
- `txd`  out  1  serial line, registered; idle high.
- `tbr`  out  1  transmit buffer ready: holding buffer empty, a write will be accepted.
- `tx_busy`  out  1  high while a frame is on the line (state != IDLE).
- `tx_overrun`  out  1  sticky: a `write` arrived while `tbr`=0; cleared only by `rst`.

## Operation
- Storage: 8-bit holding buffer with a full flag; 8-bit shift register; 4-bit tick counter; 3-bit bit index; state register.
- States: IDLE, START, DATA, STOP.
- Write: with `write`=1 and `tbr`=1, the buffer takes `tx_data` and full is set. With `write`=1 and `tbr`=0, data is dropped, buffer unchanged, `tx_overrun` set.
- Load: in IDLE with buffer full, on the next `clk` the buffer moves to the shift register, full clears, tick counter and bit index clear, state goes to START, `txd` goes 0.
- Tick counter increments on each `tx_enable` while not IDLE. A bit ends on a `tx_enable` seen with tick counter = 15; the counter wraps to 0 on that tick.
- START end: state DATA, `txd` = shift[0].
- DATA end: if bit index = 7, state STOP and `txd` = 1. Otherwise shift right, increment the bit index, and set `txd` = next bit.
- STOP end: if the buffer is full, load it the same cycle (state START, `txd` = 0, no idle gap). Otherwise go to IDLE with `txd` = 1.
- `tbr` = !full, registered. `tx_busy` = (state != IDLE).
- `tx_enable` is ignored in IDLE.
- `write` accepted in the same cycle that a load empties the buffer is not possible. `tbr` was 0 in that cycle, so the write counts as an overrun.

## Timing
- Reset values: `txd`=1, `tbr`=1, `tx_busy`=0, `tx_overrun`=0, state IDLE, buffer empty, counters 0.
- `rst` mid-frame: on the next edge `txd`=1, the frame is aborted and buffered data is discarded. No partial stop bit is emitted.
- Write at edge N while IDLE and empty: `tbr`=0 after N; load at N+1; `txd`=0 and `tbr`=1 after N+1. Write to start-bit latency is 2 `clk`.
- Each bit lasts exactly 16 `tx_enable` pulses; a frame is 160 pulses.
- With `tx_enable` held high, each bit is 16 `clk` and the frame is 160 `clk`.
- The start bit runs from the load edge to the 16th subsequent `tx_enable`. The first bit may be short by up to one tick period, because tick phase is not realigned at load.
- A second byte may be written as soon as `tbr`=1, i.e. during the frame in progress. It starts exactly at the end of the current stop bit.

## Test plan
- Single byte: `tx_enable`=1 constant, write 0xA5 while idle. `txd` is 1 for 2 `clk`, then 16-`clk` bits 0,1,0,1,0,0,1,0,1,1, then idle 1. `tx_busy` is high for 160 `clk`.
- Back-to-back: write 0x55, then write 0x0F as soon as `tbr`=1. The stop bit of 0x55 is followed immediately by the start bit of 0x0F. Total busy is 320 `clk`, `tx_overrun`=0.
- Overrun: write 0x11, then 0x22 while `tbr`=1, then 0x33 while `tbr`=0. `tx_overrun`=1; the line carries 0x11 then 0x22 only.
- Slow tick: `tx_enable` every 4th `clk`, write 0x80. Each bit is 64 `clk`; the data bits are 0×7 then 1.
- Reset mid-frame: assert `rst` for 1 `clk` during DATA bit 3 of 0xF0. `txd`=1, `tbr`=1, `tx_busy`=0 on the next edge, and there is no further activity.
- Loopback: connect `txd` to the SPART receiver with a shared baud tick and send 0x00, 0xFF, 0x3C. The receiver asserts `rda` with matching `rx_out` for each byte.

Source files
------------

// File: rtl/spart_tx_if.sv
// Bus-side signal bundle of the SPART transmitter: baud tick, write strobe
// and byte in, serial line and status flags out.
interface spart_tx_if;
    logic       tx_enable;
    logic       write;
    logic [7:0] tx_data;
    logic       txd;
    logic       tbr;
    logic       tx_busy;
    logic       tx_overrun;

    modport master (
        output tx_enable, write, tx_data,
        input  txd, tbr, tx_busy, tx_overrun
    );

    modport slave (
        input  tx_enable, write, tx_data,
        output txd, tbr, tx_busy, tx_overrun
    );
endinterface

// File: rtl/spart_tx.sv
// SPART transmitter: one-entry holding buffer feeding an 8N1 serializer
// timed by a 16x baud tick, allowing back-to-back frames with no idle gap.
module spart_tx (
    input logic       clk,
    input logic       rst,
    spart_tx_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

    txState_t   state_q, state_d;
    logic [7:0] buf_q, buf_d;
    logic       full_q, full_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bitIdx_q, bitIdx_d;
    logic       txd_q, txd_d;
    logic       tbr_q, tbr_d;
    logic       overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            buf_q     <= 8'h00;
            full_q    <= 1'b0;
            shift_q   <= 8'h00;
            tick_q    <= 4'd0;
            bitIdx_q  <= 3'd0;
            txd_q     <= 1'b1;
            tbr_q     <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            full_q    <= full_d;
            shift_q   <= shift_d;
            tick_q    <= tick_d;
            bitIdx_q  <= bitIdx_d;
            txd_q     <= txd_d;
            tbr_q     <= tbr_d;
            overrun_q <= overrun_d;
        end
    end

    // A load can only happen while the buffer is full, so it never collides
    // with an accepted write; a write during a load is always an overrun.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        full_d    = full_q;
        shift_d   = shift_q;
        tick_d    = tick_q;
        bitIdx_d  = bitIdx_q;
        txd_d     = txd_q;
        overrun_d = overrun_q;

        if (bus.write) begin
            if (tbr_q) begin
                buf_d  = bus.tx_data;
                full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (state_q == IDLE) begin
            if (full_q) begin
                shift_d  = buf_q;
                full_d   = 1'b0;
                tick_d   = 4'd0;
                bitIdx_d = 3'd0;
                state_d  = START;
                txd_d    = 1'b0;
            end
        end else if (bus.tx_enable) begin
            tick_d = tick_q + 4'd1;
            if (tick_q == 4'd15) begin
                case (state_q)
                    START: begin
                        state_d = DATA;
                        txd_d   = shift_q[0];
                    end
                    DATA: begin
                        if (bitIdx_q == 3'd7) begin
                            state_d = STOP;
                            txd_d   = 1'b1;
                        end else begin
                            shift_d  = {1'b0, shift_q[7:1]};
                            bitIdx_d = bitIdx_q + 3'd1;
                            txd_d    = shift_q[1];
                        end
                    end
                    STOP: begin
                        if (full_q) begin
                            shift_d  = buf_q;
                            full_d   = 1'b0;
                            bitIdx_d = 3'd0;
                            state_d  = START;
                            txd_d    = 1'b0;
                        end else begin
                            state_d = IDLE;
                            txd_d   = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        tbr_d = !full_d;
    end

    assign bus.txd        = txd_q;
    assign bus.tbr        = tbr_q;
    assign bus.tx_busy    = (state_q != IDLE);
    assign bus.tx_overrun = overrun_q;

endmodule
